// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_m;
  logic [2*XLEN-1:0] r_acc;
  logic              r_qneg, r_rneg;
  logic              w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic              w_div0, w_ovf, w_fast, w_ge;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_diff, w_quo, w_rem, w_res;
  logic [XLEN:0]     w_add, w_sh;
  logic [2*XLEN-1:0] w_init, w_step, w_prod;

  assign w_accept = r_state == IDLE && i_start && !i_flush;
  assign w_is_div = i_funct3[2];
  assign w_a_sgn  = w_is_div ? !i_funct3[0] : ^i_funct3[1:0];
  assign w_b_sgn  = w_is_div ? !i_funct3[0] : i_funct3[1:0] == 2'b01;
  assign w_a_neg  = w_a_sgn && i_rs1_data[XLEN-1];
  assign w_b_neg  = w_b_sgn && i_rs2_data[XLEN-1];
  assign w_a_mag  = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_b_mag  = w_b_neg ? -i_rs2_data : i_rs2_data;
  assign w_div0   = w_is_div && i_rs2_data == '0;
  assign w_ovf    = w_is_div && !i_funct3[0] && i_rs1_data == MIN_NEG && &i_rs2_data;
  assign w_fast   = w_div0 || w_ovf;
  // Fast-path ops preload the accumulator with their final {remainder, quotient}.
  assign w_init   = w_div0 ? {i_rs1_data, {XLEN{1'b1}}} :
                    w_ovf  ? {{XLEN{1'b0}}, MIN_NEG} :
                             {{XLEN{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
  assign w_add    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_sh     = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge     = w_sh >= {1'b0, r_m};
  assign w_diff   = w_sh[XLEN-1:0] - r_m;
  assign w_step   = r_funct3[2] ? {w_ge ? w_diff : w_sh[XLEN-1:0], r_acc[XLEN-2:0], w_ge}
                                : {w_add, r_acc[XLEN-1:1]};
  assign w_prod   = r_qneg ? -r_acc : r_acc;
  assign w_quo    = r_qneg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem    = r_rneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_res    = r_funct3[2] ? (r_funct3[1] ? w_rem : w_quo)
                                : (r_funct3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  assign o_busy   = i_reset && (w_accept || r_state == CALC);

  // Next state: flush returns to IDLE from CALC/DONE, DONE always lasts one cycle.
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE && w_accept) w_next = w_fast ? DONE : CALC;
    if (r_state == CALC && !i_flush) w_next = r_cnt == CW'(XLEN-1) ? DONE : CALC;
  end

  // State, iteration datapath and registered result/done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      o_result  <= '0;
      o_rd_addr <= '0;
      o_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      o_done  <= r_state == DONE && !i_flush;
      if (r_state == DONE && !i_flush) begin
        o_result  <= w_res;
        o_rd_addr <= r_rd;
      end
      if (w_accept) begin
        r_cnt    <= '0;
        r_funct3 <= i_funct3;
        r_rd     <= i_rd_addr;
        r_m      <= w_is_div ? w_b_mag : w_a_mag;
        r_acc    <= w_init;
        r_qneg   <= !w_fast && (w_a_neg ^ w_b_neg);
        r_rneg   <= !w_fast && w_a_neg;
      end else if (r_state == CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: vector table, corner sequences and random ops against an arithmetic model
module tb_ex_muldiv_unit;
  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_busy, o_done;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;
  int          checks = 0, errors = 0;
  logic [31:0] last;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    bit          fast;
  } vec_t;
  vec_t vecs[12];

  ex_muldiv_unit #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_funct3(i_funct3),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
    .i_flush(i_flush), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_rd_addr(o_rd_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (f3[2] && b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
    case (f3)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: p = sa / sb;
      3'd5: p = ua / ub;
      3'd6: p = sa % sb;
      default: p = ua % ub;
    endcase
    return (f3[2] || f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic watch_no_done(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_clk);
      if (o_done || o_busy) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic [4:0] rd, input bit fast);
    int n, busy;
    @(negedge i_clk);
    i_start = 1'b1;
    i_funct3 = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr = rd;
    #1 busy = int'(o_busy);
    @(negedge i_clk);
    i_start = 1'b0;
    n = 1;
    while (!o_done && n < 60) begin
      busy += int'(o_busy);
      @(negedge i_clk);
      n++;
    end
    chk($sformatf("latency f3=%0d", f3), 32'(n), fast ? 32'd2 : 32'd34);
    chk($sformatf("busy_cycles f3=%0d", f3), 32'(busy), fast ? 32'd1 : 32'd33);
    chk($sformatf("result f3=%0d a=%08h b=%08h", f3, a, b), o_result, exp);
    chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, rd});
    @(negedge i_clk);
    chk("done_pulse", {31'd0, o_done}, 32'd0);
    chk("result_hold", o_result, exp);
    last = exp;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{3'd6, 32'h1234,       32'd0,         32'h1234,      1'b1};
    vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[10] = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
    vecs[11] = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
    i_reset = 1'b0;
    i_start = 1'b1;
    i_flush = 1'b0;
    i_funct3 = 3'd0;
    i_rs1_data = 32'd3;
    i_rs2_data = 32'd4;
    i_rd_addr = 5'd9;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_rd", {27'd0, o_rd_addr}, 32'd0);
    i_start = 1'b0;
    i_reset = 1'b1;
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 5'(i + 1), vecs[i].fast);
    // flush in CALC at counter 10
    @(negedge i_clk);
    i_start = 1'b1;
    i_funct3 = 3'd5;
    i_rs1_data = 32'd1000;
    i_rs2_data = 32'd3;
    i_rd_addr = 5'd20;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flush_calc_busy", {31'd0, o_busy}, 32'd0);
    watch_no_done("flush_calc_nodone", 40);
    chk("flush_calc_result", o_result, last);
    run_op(3'd5, 32'd1000, 32'd3, 32'd333, 5'd20, 1'b0);
    // flush in DONE
    @(negedge i_clk);
    i_start = 1'b1;
    i_funct3 = 3'd0;
    i_rs1_data = 32'd3;
    i_rs2_data = 32'd5;
    i_rd_addr = 5'd21;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (32) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    watch_no_done("flush_done_nodone", 10);
    chk("flush_done_result", o_result, last);
    // flush together with start in IDLE
    @(negedge i_clk);
    i_start = 1'b1;
    i_flush = 1'b1;
    #1 chk("flush_start_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    i_flush = 1'b0;
    watch_no_done("flush_start_nodone", 40);
    // reset at counter 5 with start held
    @(negedge i_clk);
    i_start = 1'b1;
    i_funct3 = 3'd0;
    i_rs1_data = 32'd5;
    i_rs2_data = 32'd9;
    i_rd_addr = 5'd7;
    @(negedge i_clk);
    repeat (5) @(negedge i_clk);
    i_reset = 1'b0;
    #1 chk("rst_mid_busy_comb", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    chk("rst_mid_result", o_result, 32'd0);
    chk("rst_mid_rd", {27'd0, o_rd_addr}, 32'd0);
    chk("rst_mid_done", {31'd0, o_done}, 32'd0);
    watch_no_done("rst_hold_idle", 4);
    i_start = 1'b0;
    i_reset = 1'b1;
    watch_no_done("rst_release_idle", 40);
    last = 32'd0;
    run_op(3'd0, 32'd5, 32'd9, 32'd45, 5'd7, 1'b0);
    // randomized ops
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      int r;
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (r == 2) b = 32'($urandom_range(1, 15));
      if (r == 3) a = 32'($urandom_range(0, 15));
      run_op(f3, a, b, model(f3, a, b), 5'($urandom_range(1, 31)),
             f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
